// File: rtl/axi_bram_pkg.sv
// Shared constants, state type and helpers for the AXI4-Lite to BRAM port bridge.
package axi_bram_pkg;

  localparam logic [1:0] RESP_OKAY = 2'd0;

  typedef enum logic [2:0] {
    IDLE,
    RD_ISSUE,
    RD_WAIT,
    RD_RESP,
    WR_ISSUE,
    WR_RESP
  } state_t;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/axi_bram_port.sv
// AXI4-Lite slave giving single-beat read/write access to one port of a
// (possibly wider) BRAM, one transaction outstanding at a time.
module axi_bram_port
  import axi_bram_pkg::*;
#(
  parameter int AXI_DATA_WIDTH  = 32,
  parameter int AXI_ADDR_WIDTH  = 16,
  parameter int BRAM_DATA_WIDTH = 32,
  parameter int BRAM_ADDR_WIDTH = 10,
  parameter int READ_LATENCY    = 1
) (
  input  logic                         aclk,
  input  logic                         aresetn,
  input  logic [AXI_ADDR_WIDTH-1:0]    s_axi_awaddr,
  input  logic                         s_axi_awvalid,
  output logic                         s_axi_awready,
  input  logic [AXI_DATA_WIDTH-1:0]    s_axi_wdata,
  input  logic [AXI_DATA_WIDTH/8-1:0]  s_axi_wstrb,
  input  logic                         s_axi_wvalid,
  output logic                         s_axi_wready,
  output logic [1:0]                   s_axi_bresp,
  output logic                         s_axi_bvalid,
  input  logic                         s_axi_bready,
  input  logic [AXI_ADDR_WIDTH-1:0]    s_axi_araddr,
  input  logic                         s_axi_arvalid,
  output logic                         s_axi_arready,
  output logic [AXI_DATA_WIDTH-1:0]    s_axi_rdata,
  output logic [1:0]                   s_axi_rresp,
  output logic                         s_axi_rvalid,
  input  logic                         s_axi_rready,
  output logic                         bram_porta_clk,
  output logic                         bram_porta_rst,
  output logic                         bram_porta_en,
  output logic [BRAM_DATA_WIDTH/8-1:0] bram_porta_we,
  output logic [BRAM_ADDR_WIDTH-1:0]   bram_porta_addr,
  output logic [BRAM_DATA_WIDTH-1:0]   bram_porta_wrdata,
  input  logic [BRAM_DATA_WIDTH-1:0]   bram_porta_rddata
);

  localparam int RATIO      = BRAM_DATA_WIDTH / AXI_DATA_WIDTH;
  localparam int AXI_BYTES  = AXI_DATA_WIDTH / 8;
  localparam int BRAM_BYTES = BRAM_DATA_WIDTH / 8;
  localparam int ADDR_LSB   = int'(clog2(AXI_BYTES));
  localparam int LANE_W     = int'(clog2(RATIO));
  localparam int LANE_VW    = (LANE_W > 0) ? LANE_W : 1;
  localparam int WORD_LSB   = ADDR_LSB + LANE_W;
  localparam logic [1:0] CNT_LAST = 2'(READ_LATENCY - 1);

  state_t                     state_q, state_d;
  logic [BRAM_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LANE_VW-1:0]         lane_q, lane_d;
  logic [BRAM_BYTES-1:0]      we_q, we_d;
  logic [BRAM_DATA_WIDTH-1:0] wrdata_q, wrdata_d;
  logic [AXI_DATA_WIDTH-1:0]  rdata_q, rdata_d;
  logic [1:0]                 cnt_q, cnt_d;
  logic                       last_rd_q, last_rd_d;

  logic [BRAM_ADDR_WIDTH-1:0] ar_word, aw_word;
  logic [LANE_VW-1:0]         ar_lane, aw_lane;
  logic [BRAM_BYTES-1:0]      we_ext;
  logic                       wr_req, grant_rd, grant_wr;
  logic                       unused_addr_bits;

  // With RATIO 1 there is no lane field; the lane is pinned to 0.
  assign ar_word = s_axi_araddr[WORD_LSB +: BRAM_ADDR_WIDTH];
  assign aw_word = s_axi_awaddr[WORD_LSB +: BRAM_ADDR_WIDTH];
  assign ar_lane = (LANE_W == 0) ? '0 : s_axi_araddr[ADDR_LSB +: LANE_VW];
  assign aw_lane = (LANE_W == 0) ? '0 : s_axi_awaddr[ADDR_LSB +: LANE_VW];
  assign unused_addr_bits = ^{s_axi_araddr, s_axi_awaddr};

  assign wr_req = s_axi_awvalid && s_axi_wvalid;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    lane_d    = lane_q;
    we_d      = we_q;
    wrdata_d  = wrdata_q;
    rdata_d   = rdata_q;
    cnt_d     = cnt_q;
    last_rd_d = last_rd_q;
    grant_rd  = 1'b0;
    grant_wr  = 1'b0;
    we_ext    = '0;

    case (state_q)
      IDLE: begin
        // Round-robin: a read loses only when a write is also pending and the
        // previous grant was a read.
        if (aresetn) begin
          if (s_axi_arvalid && (!wr_req || !last_rd_q)) grant_rd = 1'b1;
          else if (wr_req)                               grant_wr = 1'b1;
        end
        if (grant_rd) begin
          addr_d    = ar_word;
          lane_d    = ar_lane;
          last_rd_d = 1'b1;
          state_d   = RD_ISSUE;
        end else if (grant_wr) begin
          addr_d    = aw_word;
          lane_d    = aw_lane;
          we_ext[AXI_BYTES-1:0] = s_axi_wstrb;
          we_d      = we_ext << (int'(aw_lane) * AXI_BYTES);
          wrdata_d  = {RATIO{s_axi_wdata}};
          last_rd_d = 1'b0;
          state_d   = WR_ISSUE;
        end
      end
      RD_ISSUE: begin
        cnt_d   = '0;
        state_d = RD_WAIT;
      end
      RD_WAIT: begin
        if (cnt_q == CNT_LAST) begin
          rdata_d = AXI_DATA_WIDTH'(bram_porta_rddata >> (int'(lane_q) * AXI_DATA_WIDTH));
          state_d = RD_RESP;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      RD_RESP:  if (s_axi_rready) state_d = IDLE;
      WR_ISSUE: state_d = WR_RESP;
      WR_RESP:  if (s_axi_bready) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      lane_q    <= '0;
      we_q      <= '0;
      wrdata_q  <= '0;
      rdata_q   <= '0;
      cnt_q     <= '0;
      last_rd_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      lane_q    <= lane_d;
      we_q      <= we_d;
      wrdata_q  <= wrdata_d;
      rdata_q   <= rdata_d;
      cnt_q     <= cnt_d;
      last_rd_q <= last_rd_d;
    end
  end

  assign s_axi_arready = grant_rd;
  assign s_axi_awready = grant_wr;
  assign s_axi_wready  = grant_wr;
  assign s_axi_rvalid  = (state_q == RD_RESP);
  assign s_axi_bvalid  = (state_q == WR_RESP);
  assign s_axi_rdata   = rdata_q;
  assign s_axi_rresp   = RESP_OKAY;
  assign s_axi_bresp   = RESP_OKAY;

  assign bram_porta_clk    = aclk;
  assign bram_porta_rst    = ~aresetn;
  assign bram_porta_en     = (state_q == RD_ISSUE) || (state_q == WR_ISSUE);
  assign bram_porta_we     = (state_q == WR_ISSUE) ? we_q : '0;
  assign bram_porta_addr   = addr_q;
  assign bram_porta_wrdata = wrdata_q;

endmodule

// File: doc/axi_bram_port.md
Name: axi_bram_port

Overview:
AXI4-Lite slave that gives the PS read and write access to one BRAM port.
- Supports a BRAM word wider than the AXI word (integer ratio) with lane select.
- Supports byte-strobe writes and a configurable BRAM read latency.
- Provides full AXI backpressure on reads and write responses.
- Sits between the AXI interconnect and a true-dual-port BRAM whose other port is owned by fabric logic (scope buffers, DDS tables).

Parameters:
AXI_DATA_WIDTH, 32, AXI data width in bits; 32 or 64.
AXI_ADDR_WIDTH, 16, AXI byte-address width.
BRAM_DATA_WIDTH, 32, BRAM word width; must equal AXI_DATA_WIDTH*RATIO, RATIO in {1,2,4,8}.
BRAM_ADDR_WIDTH, 10, BRAM word-address width.
READ_LATENCY, 1, cycles from the enable edge to valid rddata; 1 or 2 (output register on).

Ports:
aclk  in  1  clock
aresetn  in  1  synchronous active-low reset
s_axi_awaddr  in  AXI_ADDR_WIDTH  write address
s_axi_awvalid  in  1  write address valid
s_axi_awready  out  1  write address ready
s_axi_wdata  in  AXI_DATA_WIDTH  write data
s_axi_wstrb  in  AXI_DATA_WIDTH/8  write byte strobes
s_axi_wvalid  in  1  write data valid
s_axi_wready  out  1  write data ready
s_axi_bresp  out  2  write response, always 0 (OKAY)
s_axi_bvalid  out  1  write response valid
s_axi_bready  in  1  write response ready
s_axi_araddr  in  AXI_ADDR_WIDTH  read address
s_axi_arvalid  in  1  read address valid
s_axi_arready  out  1  read address ready
s_axi_rdata  out  AXI_DATA_WIDTH  read data (registered)
s_axi_rresp  out  2  read response, always 0 (OKAY)
s_axi_rvalid  out  1  read data valid
s_axi_rready  in  1  read data ready
bram_porta_clk  out  1  equals aclk
bram_porta_rst  out  1  equals ~aresetn
bram_porta_en  out  1  BRAM enable
bram_porta_we  out  BRAM_DATA_WIDTH/8  BRAM byte write enables
bram_porta_addr  out  BRAM_ADDR_WIDTH  BRAM word address
bram_porta_wrdata  out  BRAM_DATA_WIDTH  BRAM write data
bram_porta_rddata  in  BRAM_DATA_WIDTH  BRAM read data

Behaviour:
- Clock is aclk; reset is aresetn, synchronous, active-low.
- Reset:
  - State IDLE; arready, awready, wready, rvalid, bvalid, en and we all 0.
  - rdata and addr are 0.
  - Asserting reset mid-transaction aborts it; no BRAM write occurs unless en/we had already been driven.
- Address mapping:
  - ADDR_LSB = clog2(AXI_DATA_WIDTH/8); LANE_W = clog2(RATIO).
  - lane = addr[ADDR_LSB +: LANE_W].
  - BRAM word = addr[ADDR_LSB+LANE_W +: BRAM_ADDR_WIDTH].
  - Upper bits are ignored, so the address space wraps.
- States:
  - IDLE -> RD_ISSUE -> RD_WAIT -> RD_RESP -> IDLE.
  - IDLE -> WR_ISSUE -> WR_RESP -> IDLE.
- IDLE:
  - arready = 1 when a read is granted.
  - awready = wready = 1 together only when a write is granted.
  - A write requires awvalid & wvalid in the same cycle; one without the other is never accepted.
- Arbitration, both pending in IDLE: round-robin. The grant goes to the type not served last. After reset, read wins first.
- Read, handshake in cycle T:
  - T+1: en = 1 for exactly one cycle, addr = captured word.
  - RD_WAIT counts READ_LATENCY cycles. rddata lane `lane` is captured into rdata at the end of cycle T+1+READ_LATENCY.
  - rvalid rises in cycle T+2+READ_LATENCY and is held with stable rdata until rready; IDLE is re-entered the next cycle.
- Write, handshake in cycle T:
  - T+1: en = 1, and we = wstrb shifted to lane position (other lanes 0).
  - wrdata = wdata replicated across all lanes.
  - T+2: bvalid = 1, held until bready.
- Outstanding transactions: at most one; arready/awready are 0 in every non-IDLE state.
- BRAM outputs: en and we are 0 in every cycle except the issue cycle.

Decomposition:
- Shared package (axi_bram_pkg):
  - clog2 function.
  - RESP_OKAY = 2'd0.
  - State encoding constants (IDLE, RD_ISSUE, RD_WAIT, RD_RESP, WR_ISSUE, WR_RESP).
- No sub-module; the lane mux and strobe shift stay inline.

Test Plan:
- RATIO 1, READ_LATENCY 1: BRAM word 5 = 0xDEADBEEF. AR 0x14 at cycle 0, rready = 1 -> en at cycle 1 with addr 5; rvalid at cycle 3, rdata 0xDEADBEEF, OKAY.
- Read backpressure: rready low 4 cycles after rvalid -> rvalid and rdata stable, arready 0 throughout; then a new AR is accepted the cycle after RD_RESP exits.
- RATIO 2, BRAM 64-bit, READ_LATENCY 2: word 3 = 0x11112222_33334444. Read 0x1C -> rdata 0x11112222; read 0x18 -> 0x33334444; rvalid 4 cycles after the handshake.
- RATIO 2 write: addr 0x1C, wdata 0xAABBCCDD, wstrb 0b0011 -> cycle 1: addr 3, we 0b00110000, wrdata 0xAABBCCDD_AABBCCDD; bvalid at cycle 2.
- AR and AW+W valid in the same cycles repeatedly -> grants alternate read, write, read; awvalid without wvalid is never accepted.
- Reset after the read handshake, before rvalid -> next cycle rvalid 0, en 0, state IDLE; a following read completes normally.
